// File: rtl/rv32_types_pkg.sv
// Shared RV32 core types.
//   rv_instr_t     : raw 32-bit instruction word
//   fetch_entry_t  : fetch queue entry, instruction plus the PC it was fetched from
//   FETCH_PC_STEP  : PC increment between sequential fetches
package rv32_types;

   typedef logic [31:0] rv_instr_t;

   typedef struct packed {
      logic [31:0] pc;
      rv_instr_t   instr;
   } fetch_entry_t;

   localparam logic [31:0] FETCH_PC_STEP = 32'd4;

endpackage

// File: rtl/rv32_fetch_buffer.sv
// In-order fetch queue holding fetch_entry_t records.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop all entries (wins over push and pop)
//   push         : write push_data at the tail
//   pop          : retire the head entry (ignored when empty)
//   head         : current head entry
//   empty, full  : occupancy flags
//   count        : number of valid entries
// A push into a full queue is accepted only when a pop happens in the same cycle.
module rv32_fetch_buffer
   import rv32_types::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/rv32_fetch_stage.sv
// Fetch stage: issues sequential word fetches to instruction memory, queues returned
// words with their PC and hands them to decode one per cycle.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/addr/ready        : instruction memory request channel
//   imem_rsp_valid/data              : in-order response channel
//   redirect_valid/pc                : control-flow change, flushes and restarts fetch
//   dec_valid/instr/pc/ready         : instruction handshake towards decode
// Outstanding requests (in_flight) plus queued entries never exceed BUF_DEPTH, so
// every kept response always has a queue slot.
module rv32_fetch_stage
   import rv32_types::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   output rv_instr_t   dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0]      req_pc_q, req_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] in_flight_q, in_flight_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W:0]   credit_used;
   logic [31:0]      redirect_pc_aligned;
   logic             buf_empty, buf_full;
   logic             req_fire, rsp_keep, pop;
   fetch_entry_t     head, push_entry;

   assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

   // Credit covers queued entries and every outstanding request, stale ones included.
   assign credit_used    = {1'b0, occupancy} + {1'b0, in_flight_q};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(BUF_DEPTH));
   assign imem_req_addr  = req_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_keep   = imem_rsp_valid && !redirect_valid && (discard_q == '0);
   assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

   assign dec_valid = !rst && !buf_empty && !redirect_valid;
   assign dec_instr = head.instr;
   assign dec_pc    = head.pc;
   assign pop       = dec_valid && dec_ready;

   always_comb begin
      req_pc_d    = req_pc_q;
      rsp_pc_d    = rsp_pc_q;
      in_flight_d = in_flight_q;
      discard_d   = discard_q;
      if (redirect_valid) begin
         req_pc_d    = redirect_pc_aligned;
         rsp_pc_d    = redirect_pc_aligned;
         in_flight_d = in_flight_q - CNT_W'(imem_rsp_valid);
         // Every response still outstanding belongs to the old path. Since discard
         // is always a subset of in_flight, this stays consistent across
         // back-to-back redirects.
         discard_d   = in_flight_d;
      end else begin
         if (req_fire) req_pc_d = req_pc_q + FETCH_PC_STEP;
         if (rsp_keep) rsp_pc_d = rsp_pc_q + FETCH_PC_STEP;
         in_flight_d = in_flight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
         if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_q    <= RESET_PC_ALIGNED;
         rsp_pc_q    <= RESET_PC_ALIGNED;
         in_flight_q <= '0;
         discard_q   <= '0;
      end else begin
         req_pc_q    <= req_pc_d;
         rsp_pc_q    <= rsp_pc_d;
         in_flight_q <= in_flight_d;
         discard_q   <= discard_d;
      end
   end

   rv32_fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .empty     (buf_empty),
      .full      (buf_full),
      .count     (occupancy)
   );

   // The credit limit makes an unpaired push into a full queue impossible.
   no_overflow_a: assert property (@(posedge clk) disable iff (rst)
                                   !(rsp_keep && buf_full && !pop));

endmodule

// File: tb/tb_rv32_fetch_stage.sv
module tb_rv32_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready;

   rv32_fetch_stage #(
      .RESET_PC  (32'h0000_0100),
      .BUF_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          cyc0 = 0;
   int          lat = 1;
   int          n_acc = 0;
   int          n_pop = 0;
   int          first_pop_cyc = -1;
   logic [31:0] exp_req;
   logic [31:0] exp_pc;
   logic        hold_pending = 1'b0;
   logic [31:0] hold_addr = '0;
   logic        s_req_valid, s_dec_valid;
   logic [31:0] s_dec_pc, s_dec_instr;
   logic [31:0] mem_addr [$];
   int          mem_due [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: sample at the falling edge, score handshakes, then advance
   // the memory model (responses come back lat cycles after acceptance, data = ~addr).
   task automatic step();
      logic was_rst;
      #4;
      s_req_valid = imem_req_valid;
      s_dec_valid = dec_valid;
      s_dec_pc    = dec_pc;
      s_dec_instr = dec_instr;
      if (hold_pending && !rst && !redirect_valid) begin
         check_eq("req_hold_valid", 32'(imem_req_valid), 32'd1);
         check_eq("req_hold_addr", imem_req_addr, hold_addr);
      end
      hold_pending = imem_req_valid && !imem_req_ready;
      hold_addr    = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
         check_eq("req_addr", imem_req_addr, exp_req);
         exp_req += 32'd4;
         n_acc++;
         mem_addr.push_back(imem_req_addr);
         mem_due.push_back(cyc + lat);
      end
      if (dec_valid && dec_ready) begin
         if (n_pop == 0) first_pop_cyc = cyc;
         check_eq("dec_pc", dec_pc, exp_pc);
         check_eq("dec_instr", dec_instr, ~exp_pc);
         exp_pc += 32'd4;
         n_pop++;
      end
      was_rst = rst;
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (was_rst) begin
         mem_addr.delete();
         mem_due.delete();
      end else if (mem_due.size() > 0 && mem_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~mem_addr[0];
         void'(mem_addr.pop_front());
         void'(mem_due.pop_front());
      end
   endtask

   task automatic do_reset(input int l);
      lat            = l;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      step();
      check_eq("rst_req_valid", 32'(s_req_valid), 32'd0);
      check_eq("rst_dec_valid", 32'(s_dec_valid), 32'd0);
      rst           = 1'b0;
      exp_req       = 32'h100;
      exp_pc        = 32'h100;
      n_acc         = 0;
      n_pop         = 0;
      first_pop_cyc = -1;
      cyc0          = cyc;
   endtask

   task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_start);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      exp_req        = exp_start;
      exp_pc         = exp_start;
      step();
      check_eq("redir_req_valid", 32'(s_req_valid), 32'd0);
      check_eq("redir_dec_valid", 32'(s_dec_valid), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = 1'b1;
      exp_req        = 32'h100;
      exp_pc         = 32'h100;

      // Sequential fetch, 1-cycle memory, decode always ready.
      do_reset(1);
      step();
      check_eq("req_valid_after_rst", 32'(s_req_valid), 32'd1);
      for (int i = 0; i < 9; i++) step();
      check_eq("first_dec_latency", 32'(first_pop_cyc - cyc0), 32'd2);
      check_eq("pops_no_bubbles", 32'(n_pop), 32'd8);

      // Decode stalled: credits run out at BUF_DEPTH, head held.
      do_reset(1);
      dec_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check_eq("stall_accepts", 32'(n_acc), 32'd4);
      check_eq("stall_req_valid", 32'(s_req_valid), 32'd0);
      check_eq("stall_dec_valid", 32'(s_dec_valid), 32'd1);
      check_eq("stall_dec_pc", s_dec_pc, 32'h100);
      check_eq("stall_dec_instr", s_dec_instr, ~32'h100);
      dec_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check_eq("stall_drained", 32'(n_pop >= 4), 32'd1);
      check_eq("stall_resumed", 32'(n_acc > 4), 32'd1);

      // 3-cycle memory, redirect with 3 requests outstanding.
      do_reset(3);
      for (int i = 0; i < 3; i++) step();
      check_eq("lat3_accepts", 32'(n_acc), 32'd3);
      do_redirect(32'h0000_2002, 32'h0000_2000);
      redirect_valid = 1'b0;
      n_pop = 0;
      n_acc = 0;
      for (int i = 0; i < 15; i++) step();
      check_eq("lat3_redir_pops", 32'(n_pop > 0), 32'd1);
      check_eq("lat3_redir_reqs", 32'(n_acc > 0), 32'd1);

      // Redirect coinciding with a response, then a second redirect.
      do_reset(2);
      for (int i = 0; i < 3; i++) step();
      do_redirect(32'h0000_0300, 32'h0000_0300);
      do_redirect(32'h0000_0400, 32'h0000_0400);
      redirect_valid = 1'b0;
      n_pop = 0;
      for (int i = 0; i < 8; i++) step();
      check_eq("dbl_redir_pops", 32'(n_pop > 0), 32'd1);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check_eq("dbl_in_flight", 32'(dut.in_flight_q), 32'd0);
      check_eq("dbl_discard", 32'(dut.discard_q), 32'd0);
      imem_req_ready = 1'b1;

      // Memory ready toggling 1,0,0,1.
      do_reset(1);
      for (int i = 0; i < 16; i++) begin
         imem_req_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      imem_req_ready = 1'b1;
      check_eq("toggle_pops", 32'(n_pop > 4), 32'd1);

      // Address wrap at the top of memory.
      do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
      redirect_valid = 1'b0;
      n_acc = 0;
      n_pop = 0;
      for (int i = 0; i < 8; i++) step();
      check_eq("wrap_accepts", 32'(n_acc >= 3), 32'd1);
      check_eq("wrap_pops", 32'(n_pop >= 3), 32'd1);
      check_eq("pre_rst_dec_valid", 32'(s_dec_valid), 32'd1);

      // Reset in the middle of a stream.
      rst = 1'b1;
      step();
      check_eq("mid_rst_req_valid", 32'(s_req_valid), 32'd0);
      check_eq("mid_rst_dec_valid", 32'(s_dec_valid), 32'd0);
      rst     = 1'b0;
      exp_req = 32'h100;
      exp_pc  = 32'h100;
      n_acc   = 0;
      n_pop   = 0;
      step();
      check_eq("post_rst_dec_valid", 32'(s_dec_valid), 32'd0);
      check_eq("post_rst_req_valid", 32'(s_req_valid), 32'd1);
      for (int i = 0; i < 5; i++) step();
      check_eq("post_rst_accepts", 32'(n_acc > 0), 32'd1);
      check_eq("post_rst_pops", 32'(n_pop > 0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
